// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (busy + ROB tag), NRD combinational read ports.
// Optional commit-to-read bypass is compiled in when REGFILE_BYPASS_EN is defined.
module reg_status_file #(
    parameter  int XLEN  = 32,
    parameter  int NREG  = 32,
    parameter  int NRD   = 2,
    parameter  int TAG_W = 4,
    localparam int RID_W = $clog2(NREG)
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   rdy_in,
    input  logic                   commit_en,
    input  logic [RID_W-1:0]       commit_reg,
    input  logic [XLEN-1:0]        commit_val,
    input  logic [TAG_W-1:0]       commit_tag,
    input  logic                   rename_en,
    input  logic [RID_W-1:0]       rename_reg,
    input  logic [TAG_W-1:0]       rename_tag,
    input  logic                   flush_in,
    input  logic [NRD*RID_W-1:0]   rd_id,
    output logic [NRD*XLEN-1:0]    rd_val,
    output logic [NRD-1:0]         rd_busy,
    output logic [NRD*TAG_W-1:0]   rd_tag
);

    logic [XLEN-1:0]  val_q  [NREG];
    logic [TAG_W-1:0] tag_q  [NREG];
    logic [NREG-1:0]  busy_q;

    logic commit_hit;
    logic rename_hit;

    assign commit_hit = commit_en && (commit_reg != '0);
    assign rename_hit = rename_en && (rename_reg != '0) && !flush_in;

    // Entry 0 is never written after reset, so it stays hard-wired to zero.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NREG; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q <= '0;
        end else if (rdy_in) begin
            for (int i = 1; i < NREG; i++) begin
                if (commit_hit && commit_reg == RID_W'(i)) begin
                    val_q[i] <= commit_val;
                end
                if (flush_in) begin
                    busy_q[i] <= 1'b0;
                    tag_q[i]  <= '0;
                end else if (rename_hit && rename_reg == RID_W'(i)) begin
                    busy_q[i] <= 1'b1;
                    tag_q[i]  <= rename_tag;
                end else if (commit_hit && commit_reg == RID_W'(i) &&
                             busy_q[i] && tag_q[i] == commit_tag) begin
                    // Only the youngest producer may retire the rename.
                    busy_q[i] <= 1'b0;
                    tag_q[i]  <= '0;
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [RID_W-1:0] id;
        logic [XLEN-1:0]  val;
        logic             busy;
        logic [TAG_W-1:0] tag;

        assign id = rd_id[k*RID_W +: RID_W];

        always_comb begin
            val  = val_q[id];
            busy = busy_q[id];
            tag  = busy_q[id] ? tag_q[id] : '0;
`ifdef REGFILE_BYPASS_EN
            if (commit_en && rdy_in && id == commit_reg && commit_reg != '0) begin
                val = commit_val;
                if (busy_q[id] && tag_q[id] == commit_tag) begin
                    busy = 1'b0;
                    tag  = '0;
                end
            end
`endif
        end

        assign rd_val[k*XLEN +: XLEN]   = val;
        assign rd_busy[k]               = busy;
        assign rd_tag[k*TAG_W +: TAG_W] = tag;
    end

endmodule
